serial_mag_comp_lsb: RTL and testbench

Bit-serial magnitude comparator that takes two N-bit operands one bit pair per accepted beat, least-significant bit first. Its scan order is the opposite of the parallel MSB-first comparator. It serves serial links and shift-register datapaths where operands arrive LSB-first and a parallel comparator would need a deserializer. Each differing bit pair overrides the running verdict, so the last differing (most significant) pair decides the final e/g/l.

---
 rtl/serial_cmp_pkg.sv | 19 +
 rtl/serial_mag_comp_lsb_if.sv | 22 ++
 rtl/serial_cmp_cell.sv | 33 +++
 rtl/serial_mag_comp_lsb.sv | 93 +++++++++
 tb/tb_serial_mag_comp_lsb.sv | 145 ++++++++++++++
 5 files changed

// File: rtl/serial_cmp_pkg.sv
// Shared types and constants for the LSB-first serial magnitude comparator.
package serial_cmp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Running verdict at arm time: operands are equal until a bit pair differs.
  localparam logic VERDICT_E_INIT = 1'b1;
  localparam logic VERDICT_G_INIT = 1'b0;
  localparam logic VERDICT_L_INIT = 1'b0;

  function automatic int cnt_w(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/serial_mag_comp_lsb_if.sv
// Handshake and bit-pair bus between a bit source (master) and the comparator (slave).
interface serial_mag_comp_lsb_if;
  logic start;
  logic bit_valid;
  logic a_bit;
  logic b_bit;
  logic busy;
  logic done;
  logic e;
  logic g;
  logic l;

  modport master (
    output start, bit_valid, a_bit, b_bit,
    input  busy, done, e, g, l
  );

  modport slave (
    input  start, bit_valid, a_bit, b_bit,
    output busy, done, e, g, l
  );
endinterface

// File: rtl/serial_cmp_cell.sv
// Next running verdict from the current verdict and one bit pair.
// The sign-bit polarity path exists only when SERIAL_CMP_SIGNED_EN is defined.
module serial_cmp_cell (
  input  logic i_e,
  input  logic i_g,
  input  logic i_l,
  input  logic i_a_bit,
  input  logic i_b_bit,
  input  logic i_is_sign_bit,
  output logic o_e,
  output logic o_g,
  output logic o_l
);

  logic w_diff;
  logic w_g_new;

  assign w_diff = i_a_bit ^ i_b_bit;

`ifdef SERIAL_CMP_SIGNED_EN
  // In two's complement a set sign bit means the smaller operand.
  assign w_g_new = i_is_sign_bit ? i_b_bit : i_a_bit;
`else
  logic w_unused_sign;
  assign w_unused_sign = i_is_sign_bit;
  assign w_g_new       = i_a_bit;
`endif

  assign o_e = i_e & ~w_diff;
  assign o_g = w_diff ? w_g_new  : i_g;
  assign o_l = w_diff ? ~w_g_new : i_l;

endmodule

// File: rtl/serial_mag_comp_lsb.sv
// Bit-serial LSB-first magnitude comparator: FSM, bit counter and verdict registers.
// Define SERIAL_CMP_SIGNED_EN for two's complement operands.
module serial_mag_comp_lsb
  import serial_cmp_pkg::*;
#(
  parameter int N = 4
) (
  input  logic                clk,
  input  logic                rst,
  serial_mag_comp_lsb_if.slave bus
);

  localparam int CNT_W = cnt_w(N);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N - 1);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;
  logic             r_done;
  logic             r_e;
  logic             r_g;
  logic             r_l;

  logic w_is_last;
  logic w_e_next;
  logic w_g_next;
  logic w_l_next;

  assign w_is_last = (r_cnt == LAST_IDX);

  serial_cmp_cell u_cell (
    .i_e           (r_e),
    .i_g           (r_g),
    .i_l           (r_l),
    .i_a_bit       (bus.a_bit),
    .i_b_bit       (bus.b_bit),
    .i_is_sign_bit (w_is_last),
    .o_e           (w_e_next),
    .o_g           (w_g_next),
    .o_l           (w_l_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_e     <= 1'b0;
      r_g     <= 1'b0;
      r_l     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (bus.start) begin
            r_state <= ST_SHIFT;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_e     <= VERDICT_E_INIT;
            r_g     <= VERDICT_G_INIT;
            r_l     <= VERDICT_L_INIT;
          end
        end
        ST_SHIFT: begin
          if (bus.bit_valid) begin
            r_e <= w_e_next;
            r_g <= w_g_next;
            r_l <= w_l_next;
            if (w_is_last) begin
              r_state <= ST_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.e    = r_e;
  assign bus.g    = r_g;
  assign bus.l    = r_l;

endmodule

// File: tb/tb_serial_mag_comp_lsb.sv
// Directed self-checking bench for serial_mag_comp_lsb with N=4.
module tb_serial_mag_comp_lsb;

  logic clk;
  logic rst;
  int   tests_run;
  int   tests_failed;

  serial_mag_comp_lsb_if bus ();

  serial_mag_comp_lsb #(.N(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  // One comparison; exp is {e,g,l}. gaps[2i+:2] idle beats precede bit i.
  // With immediate set the caller is already at the negedge of a done cycle.
  task automatic run_cmp(input string tag, input logic [3:0] a, input logic [3:0] b,
                         input logic [7:0] gaps, input bit poke_start,
                         input bit immediate, input logic [2:0] exp);
    logic early_done;
    logic busy_drop;
    early_done = 1'b0;
    busy_drop  = 1'b0;
    if (!immediate) @(negedge clk);
    bus.start     = 1'b1;
    bus.bit_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check({tag, "_armed"}, {29'd0, bus.busy, bus.done, bus.e & ~bus.g & ~bus.l},
          {29'd0, 1'b1, 1'b0, 1'b1});
    bus.start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      for (int k = 0; k < int'(gaps[2*i +: 2]); k++) begin
        bus.bit_valid = 1'b0;
        bus.start     = poke_start;
        @(posedge clk);
        @(negedge clk);
        early_done = early_done | bus.done;
        busy_drop  = busy_drop | ~bus.busy;
      end
      bus.bit_valid = 1'b1;
      bus.a_bit     = a[i];
      bus.b_bit     = b[i];
      bus.start     = poke_start && (i == 1);
      @(posedge clk);
      @(negedge clk);
      if (i < 3) begin
        early_done = early_done | bus.done;
        busy_drop  = busy_drop | ~bus.busy;
      end
    end
    bus.bit_valid = 1'b0;
    bus.start     = 1'b0;
    check({tag, "_early_done"}, {31'd0, early_done}, 32'd0);
    check({tag, "_busy_held"}, {31'd0, busy_drop}, 32'd0);
    check({tag, "_done"}, {31'd0, bus.done}, 32'd1);
    check({tag, "_busy_off"}, {31'd0, bus.busy}, 32'd0);
    check({tag, "_egl"}, {29'd0, bus.e, bus.g, bus.l}, {29'd0, exp});
  endtask

  initial begin
    tests_run     = 0;
    tests_failed  = 0;
    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.bit_valid = 1'b0;
    bus.a_bit     = 1'b0;
    bus.b_bit     = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("reset_busy", {31'd0, bus.busy}, 32'd0);
    check("reset_done", {31'd0, bus.done}, 32'd0);
    check("reset_egl", {29'd0, bus.e, bus.g, bus.l}, 32'd0);

    // bit_valid while idle must not disturb anything
    bus.bit_valid = 1'b1;
    bus.a_bit     = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.bit_valid = 1'b0;
    check("idle_bitvalid", {29'd0, bus.busy, bus.done, bus.e | bus.g | bus.l}, 32'd0);

    run_cmp("gt_5_3", 4'b0101, 4'b0011, 8'h00, 1'b0, 1'b0, 3'b010);
    @(negedge clk);
    check("done_pulse_once", {31'd0, bus.done}, 32'd0);
    check("verdict_hold", {29'd0, bus.e, bus.g, bus.l}, {29'd0, 3'b010});

    run_cmp("eq_1010", 4'b1010, 4'b1010, 8'h00, 1'b0, 1'b0, 3'b100);
`ifdef SERIAL_CMP_SIGNED_EN
    run_cmp("msb_override", 4'b0001, 4'b1000, 8'h00, 1'b0, 1'b0, 3'b010);
    run_cmp("sign_8_7", 4'b1000, 4'b0111, 8'h00, 1'b0, 1'b0, 3'b001);
`else
    run_cmp("msb_override", 4'b0001, 4'b1000, 8'h00, 1'b0, 1'b0, 3'b001);
    run_cmp("sign_8_7", 4'b1000, 4'b0111, 8'h00, 1'b0, 1'b0, 3'b010);
`endif
    run_cmp("gaps_5_3", 4'b0101, 4'b0011, 8'b10_11_01_10, 1'b1, 1'b0, 3'b010);

    // reset after two of four bits aborts the comparison
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start     = 1'b0;
    bus.bit_valid = 1'b1;
    bus.a_bit     = 1'b1;
    bus.b_bit     = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus.a_bit = 1'b0;
    bus.b_bit = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst           = 1'b0;
    bus.bit_valid = 1'b0;
    check("abort_busy", {31'd0, bus.busy}, 32'd0);
    check("abort_done", {31'd0, bus.done}, 32'd0);
    check("abort_egl", {29'd0, bus.e, bus.g, bus.l}, 32'd0);
    run_cmp("after_abort", 4'b0011, 4'b0110, 8'b00_01_00_11, 1'b0, 1'b0, 3'b001);

    run_cmp("b2b_first", 4'b1100, 4'b1100, 8'h00, 1'b0, 1'b0, 3'b100);
    run_cmp("b2b_second", 4'b0111, 4'b0110, 8'h00, 1'b0, 1'b1, 3'b010);
    run_cmp("b2b_third", 4'b0010, 4'b0100, 8'b01_00_00_00, 1'b0, 1'b1, 3'b001);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
